// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory responder.
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed RV32I data memory with a fixed-latency single-outstanding request/response FSM.
// Define MISALIGN_CHECK_EN to flag misaligned half/word accesses instead of silently aligning them.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int         MEM_BYTES = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_CNT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [7:0]            mem [MEM_BYTES];

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_we;
  logic [2:0]            acc_f3;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [1:0]            size;
  logic                  legal;
  logic                  misalign;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] baddr [4];
  logic [3:0]            be;
  logic [31:0]           raw;
  logic                  unused_addr;

  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0] sz);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    if (sz == 2'b01)      r[0]   = 1'b0;
    else if (sz == 2'b10) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [2:0] f3, input logic [31:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (f3)
      3'b000: begin r = {DATA_WIDTH{w[7]}};  r[7:0]  = w[7:0];  end
      3'b001: begin r = {DATA_WIDTH{w[15]}}; r[15:0] = w[15:0]; end
      3'b010: r[31:0] = w;
      3'b100: r[7:0]  = w[7:0];
      3'b101: r[15:0] = w[15:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign unused_addr = ^bus.req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, so the live request is used.
  assign acc_we    = (state_q == IDLE) ? bus.req_we                       : we_q;
  assign acc_f3    = (state_q == IDLE) ? bus.req_funct3                   : funct3_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr[ADDR_WIDTH-1:0]     : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata                    : wdata_q;

  assign size = acc_f3[1:0];

  always_comb begin
    if (acc_we) legal = (acc_f3[2] == 1'b0) && (acc_f3[1:0] != 2'b11);
    else        legal = (acc_f3[1:0] != 2'b11) && !(acc_f3[2] && acc_f3[1]);
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign  = ((size == 2'b01) && acc_addr[0]) ||
                     ((size == 2'b10) && (acc_addr[1:0] != 2'b00));
  assign base_addr = acc_addr;
`else
  assign misalign  = 1'b0;
  assign base_addr = align_addr(acc_addr, size);
`endif

  assign acc_err = !legal || misalign;

  assign be[0] = 1'b1;
  assign be[1] = (size != 2'b00);
  assign be[2] = (size == 2'b10);
  assign be[3] = (size == 2'b10);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      baddr[i]      = base_addr + ADDR_WIDTH'(i);
      raw[8*i +: 8] = mem[baddr[i]];
    end
  end

  // A reset on the entering edge suppresses the access, so an aborted store never lands.
  assign enter_resp = rst && (state_q != RESP) && (state_d == RESP);

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? '0 : fmt_load(acc_f3, raw);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr[ADDR_WIDTH-1:0];
      wdata_q  <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[baddr[i]] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-array reference model and literal scenarios.
module tb_data_mem_responder;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int LAT  = 2;
  localparam int MEMB = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_WIDTH(DW)) bus ();

  data_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h01030507);
  endfunction

  // Reference model: a byte array plus one outstanding request with its accept cycle.
  logic [7:0]  mem_m [MEMB];
  int          cyc     = 0;
  bit          started = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_acc   = 0;
  bit          m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  bit          m_err   = 1'b0;

  function automatic bit m_valid();
    return m_pend && ((cyc - m_acc) >= LAT);
  endfunction

  task automatic model_access();
    int     a, n;
    bit     ok;
    longint v;
    a  = int'(m_addr & 32'(MEMB - 1));
    n  = 1 << m_f3[1:0];
    ok = m_we ? (m_f3 <= 3'd2) : (m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    m_rdata = '0;
    m_err   = !ok;
`ifdef MISALIGN_CHECK_EN
    if (ok && (a % n) != 0) m_err = 1'b1;
`else
    if (ok) a = a - (a % n);
`endif
    if (m_err) return;
    if (m_we) begin
      for (int i = 0; i < n; i++) mem_m[(a + i) % MEMB] = 8'((m_wdata >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mem_m[(a + i) % MEMB]) << (8 * i);
      if (m_f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      m_rdata = 32'(v);
    end
  endtask

  always @(posedge clk) begin
    bit was_valid;
    was_valid = m_valid();
    cyc++;
    if (!rst) begin
      started = 1'b1;
      m_pend  = 1'b0;
    end else if (m_pend) begin
      if (was_valid && bus.resp_ready) m_pend = 1'b0;
    end else if (bus.req_valid) begin
      m_pend  = 1'b1;
      m_acc   = cyc;
      m_we    = bus.req_we;
      m_f3    = bus.req_funct3;
      m_addr  = bus.req_addr;
      m_wdata = bus.req_wdata;
    end
    if (rst && m_pend && cyc == m_acc + LAT) model_access();
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = m_valid();
      check("req_ready", 32'(bus.req_ready), 32'(!m_pend));
      check("resp_valid", 32'(bus.resp_valid), 32'(ev));
      if (ev) begin
        check("resp_rdata", bus.resp_rdata, m_rdata);
        check("resp_err", 32'(bus.resp_err), 32'(m_err));
      end
    end
  end

  task automatic junk();
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int g;
    g = 0;
    while (m_pend && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
  endtask

  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rd, output bit er, output int lat);
    int g, t_acc;
    issue(we, f3, addr, wdata);
    t_acc = cyc;
    g = 0;
    while (!bus.resp_valid && g < 60) begin
      junk();
      @(negedge clk);
      g++;
    end
    lat = cyc - t_acc + 1;
    if (!bus.resp_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_valid_timeout: got 0, expected 1 within 60 cycles (t=%0t)", $time);
    end
    for (int h = 0; h < hold; h++) begin
      junk();
      @(negedge clk);
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;
    bit          rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 128; i++) txn(1'b1, 3'b010, 32'(i * 4), init_word(i), 0, rd, er, lat);

    txn(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw rdata zero", rd, 32'd0);
    check("sw err", 32'(er), 32'd0);
    txn(1'b0, 3'b010, 32'h010, 32'h0, 1, rd, er, lat);
    check("lw 0x010", rd, 32'hDEADBEEF);
    check("lw latency", 32'(lat), 32'(LAT + 1));

    txn(1'b1, 3'b000, 32'h013, 32'h00000080, 0, rd, er, lat);
    txn(1'b0, 3'b000, 32'h013, 32'h0, 0, rd, er, lat);
    check("lb 0x013", rd, 32'hFFFFFF80);
    txn(1'b0, 3'b100, 32'h013, 32'h0, 2, rd, er, lat);
    check("lbu 0x013", rd, 32'h00000080);
    txn(1'b0, 3'b010, 32'h010, 32'h0, 0, rd, er, lat);
    check("lw after sb", rd, 32'h80ADBEEF);

    txn(1'b1, 3'b001, 32'h102, 32'h00001234, 5, rd, er, lat);
    check("sh held rdata", rd, 32'd0);
    check("req_ready after release", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 3'b001, 32'h102, 32'h0, 0, rd, er, lat);
    check("lh 0x102", rd, 32'h00001234);

    txn(1'b0, 3'b010, 32'h001, 32'h0, 0, rd, er, lat);
`ifdef MISALIGN_CHECK_EN
    check("lw 0x001 rdata", rd, 32'd0);
    check("lw 0x001 err", 32'(er), 32'd1);
`else
    check("lw 0x001 rdata", rd, init_word(0));
    check("lw 0x001 err", 32'(er), 32'd0);
`endif

    txn(1'b0, 3'b011, 32'h010, 32'h0, 0, rd, er, lat);
    check("load f3=011 err", 32'(er), 32'd1);
    check("load f3=011 rdata", rd, 32'd0);
    txn(1'b1, 3'b100, 32'h010, 32'hFFFFFFFF, 0, rd, er, lat);
    check("store f3=100 err", 32'(er), 32'd1);
    txn(1'b0, 3'b010, 32'h1010, 32'h0, 0, rd, er, lat);
    check("lw wrap 0x1010", rd, 32'h80ADBEEF);

    issue(1'b1, 3'b010, 32'h020, 32'h11111111);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort resp_rdata", bus.resp_rdata, 32'd0);
    check("abort resp_err", 32'(bus.resp_err), 32'd0);
    rst = 1'b1;
    txn(1'b0, 3'b010, 32'h020, 32'h0, 0, rd, er, lat);
    check("lw after aborted sw", rd, init_word(8));

    for (int k = 0; k < 300; k++) begin
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rf3 = 3'($urandom_range(0, 7));
      else if (rwe) rf3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = 3'b100;
          default: rf3 = 3'b101;
        endcase
      end
      raddr = ($urandom & 32'hFFFFF000) | ($urandom & 32'h000001FF);
      txn(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 3)), rd, er, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning the byte-address bits used (4 KiB array).
REQ-003 SHALL have parameter LATENCY, default 2, legal range 0..15, meaning the wait cycles before a response.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-009 SHALL have port req_funct3, input, 3 bits: access size and sign, using RV32I load/store encoding.
REQ-010 SHALL have port req_addr, input, DATA_WIDTH bits: the byte address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-013 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 SHALL have port resp_rdata, output, DATA_WIDTH bits: load result, already extended.
REQ-015 SHALL have port resp_err, output, 1 bit: the access was illegal (bad funct3 or misaligned).

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP, with req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where req_valid&&req_ready, latching we, funct3, addr[ADDR_WIDTH-1:0] and wdata.
REQ-018 SHALL on accept go to WAIT with the counter set to LATENCY, or go directly to RESP if LATENCY=0.
REQ-019 SHALL in WAIT decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-020 SHALL assert resp_valid exactly LATENCY+1 cycles after the accepting edge.
REQ-021 SHALL perform the array read/write on the edge entering RESP, committing each store exactly once.
REQ-022 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a new request on the same edge that returns the FSM to IDLE, giving a minimum of LATENCY+2 cycles per transaction.
REQ-024 SHALL store data little-endian in a byte array of 2^ADDR_WIDTH bytes, with upper address bits ignored (wrap-around).
REQ-025 SHALL implement loads as 000 lb (sign-extend byte), 001 lh (sign-extend half), 010 lw, 100 lbu and 101 lhu (zero-extend).
REQ-026 SHALL implement stores as 000 sb, 001 sh and 010 sw, writing only the addressed bytes.
REQ-027 SHALL set resp_err=1, perform no write and return rdata=0 for any other funct3, including load 011/110/111 and store 1xx/011.
REQ-028 SHALL return resp_rdata=0 for every store response.
REQ-029 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-030 SHALL while rst=0 go to IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-031 SHALL on reset in WAIT abort the pending store without writing it; a store already committed in RESP remains.
REQ-032 SHALL NOT clear array contents on reset.

Configuration
REQ-033 SHALL, when macro MISALIGN_CHECK_EN is defined, flag a half access with addr[0]!=0 or a word access with addr[1:0]!=0 with resp_err=1, perform no write and return rdata=0.
REQ-034 SHALL, when MISALIGN_CHECK_EN is undefined, force the low address bits to zero per access size and never set resp_err for alignment.

Verification
REQ-035 SHALL pass this scenario: after reset, sw 0xDEADBEEF to 0x010, then lw 0x010 -> rdata=0xDEADBEEF, with resp_valid 3 cycles after accept (LATENCY=2).
REQ-036 SHALL pass this scenario: sb 0x80 to 0x013, then lb 0x013 -> 0xFFFFFF80, lbu 0x013 -> 0x00000080, and lw 0x010 -> 0x80ADBEEF.
REQ-037 SHALL pass this scenario: sh 0x1234 to 0x102 with resp_ready held 0 for 5 cycles -> resp_valid and outputs stable for those cycles, then req_ready=1 on the cycle after resp_ready=1.
REQ-038 SHALL pass this scenario: lw at 0x001 with the macro defined -> resp_err=1 and rdata=0; without the macro -> the data at 0x000 and resp_err=0.
REQ-039 SHALL pass this scenario: sw 0x11111111 to 0x020 with rst=0 asserted one cycle after accept, then lw 0x020 -> the prior contents, unchanged.
REQ-040 SHALL pass this scenario: lw at 0x1010 with ADDR_WIDTH=12 -> returns the contents of 0x010 (wrap-around).
